// File: rtl/disp_share_arb_if.sv
// Bundle between the display requesters and the shared-display arbiter.
// The arbiter is the slave side; the requesters and disp_hex_mux are the master side.
interface disp_share_arb_if #(
    parameter int N = 4
);
    logic [N-1:0]    req;
    logic [16*N-1:0] val;
    logic [4*N-1:0]  dp_req;
    logic [N-1:0]    grant;
    logic [3:0]      hex3;
    logic [3:0]      hex2;
    logic [3:0]      hex1;
    logic [3:0]      hex0;
    logic [3:0]      dp_in;
    logic            busy;

    modport master (
        output req, val, dp_req,
        input  grant, hex3, hex2, hex1, hex0, dp_in, busy
    );

    modport slave (
        input  req, val, dp_req,
        output grant, hex3, hex2, hex1, hex0, dp_in, busy
    );
endinterface

// File: rtl/disp_share_arb.sv
// Round-robin owner of the 4-digit seven-segment display. An owner keeps the
// display for at least DWELL cycles unless it releases early.
module disp_share_arb #(
    parameter int N     = 4,
    parameter int DWELL = 100_000_000
) (
    input  logic             clk,
    input  logic             reset,
    disp_share_arb_if.slave  bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;

    localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [IW-1:0] LAST_RST = IW'(N - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    grant_q, grant_d;
    logic            busy_q;
    logic [15:0]     hex_q, hex_d;
    logic [3:0]      dp_q, dp_d;

    logic [IW-1:0]   base_s;
    logic [IW-1:0]   win_s;
    logic            win_found_s;
    logic            own_req_s;
    logic [15:0]     val_arr_s [N];
    logic [3:0]      dp_arr_s  [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign val_arr_s[gi] = bus.val[16*gi +: 16];
        assign dp_arr_s[gi]  = bus.dp_req[4*gi +: 4];
    end

    // Round-robin search: start one past the base and wrap, so the base itself is checked last.
    always_comb begin
        base_s      = (state_q == HOLD) ? owner_q : last_q;
        win_s       = {IW{1'b0}};
        win_found_s = 1'b0;
        for (int off = N; off >= 1; off--) begin
            if (bus.req[(int'(base_s) + off) % N]) begin
                win_s       = IW'((int'(base_s) + off) % N);
                win_found_s = 1'b1;
            end else begin
                win_found_s = win_found_s;
            end
        end
        own_req_s = bus.req[owner_q];
    end

    // Ownership and dwell-counter next state.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found_s) begin
                    state_d = HOLD;
                    owner_d = win_s;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            HOLD: begin
                if (!own_req_s) begin
                    // Release ignores the dwell counter; the owner's req is low so it cannot win.
                    last_d = owner_q;
                    if (win_found_s) begin
                        state_d = HOLD;
                        owner_d = win_s;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = CNT_ZERO;
                    end
                end else if (cnt_q == CNT_ZERO) begin
                    owner_d = win_s;
                    cnt_d   = CNT_LOAD;
                    if (win_s != owner_q) begin
                        last_d = owner_q;
                    end else begin
                        last_d = last_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Output image follows the next owner so grant and display change on the same edge.
    always_comb begin
        grant_d = {N{1'b0}};
        if (state_d == HOLD) begin
            grant_d[owner_d] = 1'b1;
            hex_d            = val_arr_s[owner_d];
            dp_d             = dp_arr_s[owner_d];
        end else begin
            hex_d = 16'h0000;
            dp_d  = 4'b1111;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= {IW{1'b0}};
            last_q  <= LAST_RST;
            cnt_q   <= CNT_ZERO;
            grant_q <= {N{1'b0}};
            busy_q  <= 1'b0;
            hex_q   <= 16'h0000;
            dp_q    <= 4'b1111;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            busy_q  <= |grant_d;
            hex_q   <= hex_d;
            dp_q    <= dp_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;
    assign bus.hex3  = hex_q[15:12];
    assign bus.hex2  = hex_q[11:8];
    assign bus.hex1  = hex_q[7:4];
    assign bus.hex0  = hex_q[3:0];
    assign bus.dp_in = dp_q;
endmodule

// File: tb/tb_disp_share_arb.sv
// Scoreboard bench for disp_share_arb: directed scenarios plus random traffic
// checked cycle by cycle against a tenure-based reference model.
module tb_disp_share_arb;
    localparam int N     = 4;
    localparam int DWELL = 4;

    logic clk;
    logic reset;

    disp_share_arb_if #(.N(N)) bus ();

    disp_share_arb #(.N(N), .DWELL(DWELL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected image: {grant[3:0], busy, hex[15:0], dp[3:0]}
    logic [24:0] exp_q [$];
    string       name_q [$];
    int          errors = 0;
    int          checks = 0;

    // reference model state
    int          m_owner;
    int          m_last;
    int          m_held;

    logic [3:0]  r;
    logic [15:0] v [N];
    logic [3:0]  d [N];
    logic        rst;

    function automatic int rr_pick(int base, logic [3:0] rq);
        for (int o = 1; o <= N; o++) begin
            if (rq[(base + o) % N]) return (base + o) % N;
        end
        return -1;
    endfunction

    task automatic model_edge(output logic [24:0] e);
        int w;
        if (rst) begin
            m_owner = -1;
            m_last  = N - 1;
            m_held  = 0;
        end else if (m_owner < 0) begin
            w = rr_pick(m_last, r);
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
            end
        end else if (!r[m_owner]) begin
            w      = rr_pick(m_owner, r);
            m_last = m_owner;
            m_owner = w;
            m_held  = (w >= 0) ? 1 : 0;
        end else if (m_held == DWELL) begin
            w = rr_pick(m_owner, r);
            if (w != m_owner) m_last = m_owner;
            m_owner = w;
            m_held  = 1;
        end else begin
            m_held = m_held + 1;
        end
        if (m_owner < 0) e = {4'b0000, 1'b0, 16'h0000, 4'b1111};
        else             e = {4'(1 << m_owner), 1'b1, v[m_owner], d[m_owner]};
    endtask

    task automatic step(input string nm);
        logic [24:0] e;
        reset = rst;
        bus.req = r;
        for (int i = 0; i < N; i++) begin
            bus.val[16*i +: 16]  = v[i];
            bus.dp_req[4*i +: 4] = d[i];
        end
        model_edge(e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    task automatic run(input int n, input string nm);
        for (int k = 0; k < n; k++) step(nm);
    endtask

    // Monitor: compares the DUT image against the scoreboard just after each rising edge.
    always @(posedge clk) begin
        logic [24:0] e;
        logic [24:0] got;
        string       nm;
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {bus.grant, bus.busy, bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.dp_in};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s t=%0t: got grant=%b busy=%b hex=%h dp=%b, want grant=%b busy=%b hex=%h dp=%b",
                         nm, $time, got[24:21], got[20], got[19:4], got[3:0],
                         e[24:21], e[20], e[19:4], e[3:0]);
            end
        end
    end

    task automatic do_reset(input int n);
        rst = 1'b1;
        run(n, "reset");
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        r   = 4'b0000;
        for (int i = 0; i < N; i++) begin
            v[i] = 16'(16'h1111 * (i + 1));
            d[i] = 4'b1111;
        end
        m_owner = -1;
        m_last  = N - 1;
        m_held  = 0;

        do_reset(2);

        // full contention: 0001,0010,0100,1000,0001 each for DWELL cycles
        r = 4'b1111;
        run(20, "full_contention");

        // reset in the middle of a tenure
        do_reset(1);
        r = 4'b0010; v[1] = 16'h1234;
        run(2, "pre_reset_hold");
        rst = 1'b1;
        run(1, "reset_mid_hold");
        rst = 1'b0;
        run(3, "post_reset_regrant");

        // single requester keeps ownership across expiries
        do_reset(1);
        r = 4'b0100; v[2] = 16'hBEEF; d[2] = 4'b1011;
        run(14, "single_requester");

        // early release at dwell cycle 2
        do_reset(1);
        r = 4'b0011;
        run(2, "early_release_pre");
        r = 4'b0010;
        run(6, "early_release");

        // live value change of owner 3
        do_reset(1);
        r = 4'b1000; v[3] = 16'h00FF; d[3] = 4'b0110;
        run(3, "live_pre");
        v[3] = 16'hA5A5;
        run(3, "live_change");

        // late arrival waits for expiry, then all drop
        do_reset(1);
        r = 4'b0100;
        run(2, "late_pre");
        r = 4'b0101;
        run(6, "late_arrival");
        r = 4'b0000;
        run(3, "all_dropped");

        // random traffic
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) begin
                int j;
                j    = $urandom_range(0, N - 1);
                v[j] = 16'($urandom);
                d[j] = 4'($urandom_range(0, 15));
            end
            step("random");
        end
        rst = 1'b0;
        r   = 4'b0000;
        run(2, "drain");

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
